// File: rtl/mux4_scan_ctrl.sv
// rtl/mux4_scan_ctrl.sv - scan controller for a 4:1 mux: select, settle, sample, hand off a 4-bit word
module mux4_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] ch_mask,
    output logic       sel1,
    output logic       sel2,
    input  logic       mux_y,
    output logic       busy,
    output logic [3:0] data_out,
    output logic       data_valid,
    input  logic       data_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] SETTLE_C = 3'(SETTLE);

    state_t     state_q;
    logic [3:0] mask_q;
    logic [3:0] shadow_q;
    logic [2:0] cnt_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic [3:0] data_out_q;
    logic       valid_q;

    logic [1:0] first_ch;
    logic [1:0] next_ch;
    logic       next_found;
    logic [3:0] shadow_d;

    assign sel1       = sel_q[1];
    assign sel2       = sel_q[0];
    assign busy       = busy_q;
    assign data_out   = data_out_q;
    assign data_valid = valid_q;

    // Lowest channel enabled in the incoming mask; lowest enabled channel above the current one.
    always_comb begin
        first_ch   = 2'd0;
        next_ch    = 2'd0;
        next_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_ch = 2'(k);
            end
            if (mask_q[k] && (k > int'(sel_q))) begin
                next_ch    = 2'(k);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[sel_q] = mux_y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= 4'd0;
            shadow_q   <= 4'd0;
            cnt_q      <= 3'd0;
            sel_q      <= 2'd0;
            busy_q     <= 1'b0;
            data_out_q <= 4'd0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_q <= 2'd0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (ch_mask != 4'd0) begin
                            mask_q   <= ch_mask;
                            shadow_q <= 4'd0;
                            sel_q    <= first_ch;
                            cnt_q    <= SETTLE_C;
                            state_q  <= SCAN;
                        end else begin
                            data_out_q <= 4'd0;
                            valid_q    <= 1'b1;
                            state_q    <= HOLD;
                        end
                    end
                end
                SCAN: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        shadow_q <= shadow_d;
                        if (next_found) begin
                            sel_q <= next_ch;
                            cnt_q <= SETTLE_C;
                        end else begin
                            // Final sample goes straight to the output so it is not a cycle late.
                            data_out_q <= shadow_d;
                            valid_q    <= 1'b1;
                            sel_q      <= 2'd0;
                            state_q    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    sel_q <= 2'd0;
                    if (valid_q && data_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb/tb_mux4_scan_ctrl.sv - randomized self-checking bench for mux4_scan_ctrl at SETTLE 0, 1 and 7
module tb_mux4_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start_v;
    logic [2:0] ready_v;
    logic [2:0] sel1_v;
    logic [2:0] sel2_v;
    logic [2:0] mux_y_v;
    logic [2:0] busy_v;
    logic [2:0] valid_v;
    logic [3:0] data_v [3];
    logic [3:0] ch_mask;
    logic [3:0] mux_in;

    int st_of[3] = '{0, 1, 7};
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_mux
        assign mux_y_v[g] = mux_in[{sel1_v[g], sel2_v[g]}];
    end

    mux4_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .ch_mask(ch_mask),
        .sel1(sel1_v[0]), .sel2(sel2_v[0]), .mux_y(mux_y_v[0]), .busy(busy_v[0]),
        .data_out(data_v[0]), .data_valid(valid_v[0]), .data_ready(ready_v[0])
    );
    mux4_scan_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .ch_mask(ch_mask),
        .sel1(sel1_v[1]), .sel2(sel2_v[1]), .mux_y(mux_y_v[1]), .busy(busy_v[1]),
        .data_out(data_v[1]), .data_valid(valid_v[1]), .data_ready(ready_v[1])
    );
    mux4_scan_ctrl #(.SETTLE(7)) u_dut7 (
        .clk(clk), .rst(rst), .start(start_v[2]), .ch_mask(ch_mask),
        .sel1(sel1_v[2]), .sel2(sel2_v[2]), .mux_y(mux_y_v[2]), .busy(busy_v[2]),
        .data_out(data_v[2]), .data_valid(valid_v[2]), .data_ready(ready_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the chosen DUT idle. Mux inputs switch from in0 to in1
    // right after edge tog (edge 0 accepts start). rdly = cycles of data_ready=0 in HOLD.
    task automatic run_scan(input int d, input logic [3:0] m, input logic [3:0] in0,
                            input int tog, input logic [3:0] in1, input int rdly,
                            input bit start_at_hs);
        int         s;
        int         seq[$];
        int         rank;
        int         te;
        int         len;
        logic [3:0] exp;
        s    = st_of[d];
        rank = 0;
        exp  = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                for (int r = 0; r <= s; r++) seq.push_back(k);
                te = (rank + 1) * (s + 1);
                exp[k] = (te - 1 >= tog) ? in1[k] : in0[k];
                rank++;
            end
        end
        len = seq.size();

        mux_in     = in0;
        ch_mask    = m;
        start_v[d] = 1'b1;
        ready_v[d] = (rdly == 0);
        for (int j = 0; j <= len; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start_v[d] = 1'b0;
                ch_mask    = 4'($urandom);
            end
            if (j < len) begin
                check("scan_sel", {sel1_v[d], sel2_v[d]}, seq[j]);
                check("scan_busy", busy_v[d], 1);
                check("scan_valid", valid_v[d], 0);
            end else begin
                check("done_sel", {sel1_v[d], sel2_v[d]}, 0);
                check("done_valid", valid_v[d], 1);
                check("done_busy", busy_v[d], 1);
                check("done_data", data_v[d], exp);
            end
            if (j == tog) mux_in = in1;
        end

        for (int h = 0; h < rdly; h++) begin
            start_v[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_valid", valid_v[d], 1);
            check("hold_busy", busy_v[d], 1);
            check("hold_sel", {sel1_v[d], sel2_v[d]}, 0);
            check("hold_data", data_v[d], exp);
        end

        ready_v[d] = 1'b1;
        start_v[d] = start_at_hs;
        @(negedge clk);
        check("xfer_valid", valid_v[d], 0);
        check("xfer_busy", busy_v[d], 0);
        check("xfer_sel", {sel1_v[d], sel2_v[d]}, 0);
        check("xfer_data", data_v[d], exp);
        start_v[d] = 1'b0;
        ready_v[d] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start_v = 3'b000;
        ready_v = 3'b000;
        ch_mask = 4'd0;
        mux_in  = 4'd0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_sel", {sel1_v[d], sel2_v[d]}, 0);
            check("rst_busy", busy_v[d], 0);
            check("rst_valid", valid_v[d], 0);
            check("rst_data", data_v[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Full scan, SETTLE=1, i0..i3 = 0,1,1,0
        run_scan(1, 4'b1111, 4'b0110, 1000, 4'b0110, 1, 1'b0);

        // Reset while channel 1 is selected, then a clean scan
        mux_in     = 4'b1111;
        ch_mask    = 4'b1111;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_sel", {sel1_v[1], sel2_v[1]}, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_sel", {sel1_v[1], sel2_v[1]}, 0);
        check("midrst_busy", busy_v[1], 0);
        check("midrst_valid", valid_v[1], 0);
        check("midrst_data", data_v[1], 0);
        run_scan(1, 4'b1111, 4'b1101, 1000, 4'b1101, 0, 1'b0);

        // Sparse and empty masks, SETTLE=0
        run_scan(0, 4'b1010, 4'b1010, 1000, 4'b1010, 1, 1'b0);
        run_scan(0, 4'b0000, 4'b1111, 1000, 4'b1111, 1, 1'b0);
        run_scan(0, 4'b0000, 4'b1111, 1000, 4'b1111, 0, 1'b0);

        // Backpressure
        run_scan(1, 4'b1111, 4'b1001, 1000, 4'b1001, 10, 1'b0);

        // Settle boundary, SETTLE=7: i2 drops after edge 5, sampled at edge 8
        run_scan(2, 4'b0100, 4'b0100, 5, 4'b0000, 2, 1'b0);
        run_scan(2, 4'b0100, 4'b0100, 7, 4'b0000, 1, 1'b0);

        // Start during handshake is ignored; next start accepted one cycle later
        run_scan(0, 4'b0011, 4'b0001, 1000, 4'b0001, 2, 1'b1);
        run_scan(0, 4'b1100, 4'b0100, 1000, 4'b0100, 0, 1'b1);
        run_scan(0, 4'b0110, 4'b0010, 1000, 4'b0010, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_scan($urandom_range(0, 2), 4'($urandom), 4'($urandom), $urandom_range(0, 34),
                     4'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequential scan controller that drives the select lines of the 4:1 gate-level multiplexer, samples its output, and assembles a 4-bit word. It sits directly around the mux: `sel1`/`sel2` go to the mux select inputs, and the mux output `y` returns on `mux_y`. The block steps through the enabled channels in ascending order with a programmable settle delay. It then presents the collected word on a valid/ready output handshake.

## Interface
Parameters:
- SETTLE, 1, wait cycles after each select change before sampling `mux_y`; legal range 0..7.

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a scan; sampled only in IDLE
- ch_mask  input  4  channel enable; bit k enables channel k; captured on accepted start
- sel1  output  1  mux select MSB, registered
- sel2  output  1  mux select LSB, registered; channel k = {sel1,sel2}, so channel 2 = 1,0
- mux_y  input  1  mux output under test
- busy  output  1  high in SCAN and HOLD
- data_out  output  4  bit k = sampled `mux_y` for channel k; 0 for masked channels
- data_valid  output  1  `data_out` valid
- data_ready  input  1  consumer accepts `data_out`

## Operation
- Reset applies on a clk edge with rst=1. Reset clears every register, including mid-scan and mid-HOLD. Reset values:
  - sel1=0, sel2=0
  - busy=0, data_valid=0, data_out=0
  - shadow word = 0, FSM = IDLE
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - sel = 00.
  - start=1 with ch_mask≠0: latch mask, clear the shadow word, load sel with the lowest enabled channel, load settle counter = SETTLE, go to SCAN.
  - start=1 with ch_mask=0: data_out←0, data_valid←1, go to HOLD; no channel is visited.
- SCAN:
  - While counter>0, decrement it and hold sel.
  - On the cycle counter==0, the edge writes `mux_y` into shadow[current channel].
  - If a higher enabled channel remains, that same edge loads sel with the next enabled channel and reloads counter=SETTLE.
  - Otherwise that edge sets data_out←shadow with the final bit included, data_valid←1, sel←00, and goes to HOLD.
- Masked channels are skipped entirely, cost zero cycles, and read 0.
- HOLD:
  - data_out and data_valid are stable until handshake; sel = 00.
  - An edge with data_valid=1 and data_ready=1 completes the transfer: data_valid←0, go to IDLE. data_out keeps its last value.
- start outside IDLE is ignored, including in the handshake-completion cycle; no queuing.
- ch_mask changes during SCAN have no effect; the latched copy is used.

## Timing
- Each enabled channel occupies SETTLE+1 cycles.
- Latency: with start accepted at edge 0 and N enabled channels, data_valid rises after edge N·(SETTLE+1). Zero-mask case: data_valid rises after edge 0.
- sel changes only on clock edges. `mux_y` is sampled after at least SETTLE full cycles of stable sel. With SETTLE=0, it is sampled at the end of the first cycle the select is applied.
- data_ready may already be high when data_valid rises; the transfer then completes on the next edge, giving a minimum 1 cycle in HOLD.
- Minimum start-to-start spacing: N·(SETTLE+1) + 2 cycles (scan, HOLD, IDLE).
- busy rises on the edge accepting start and falls on the handshake-completion edge.

## Test plan
- Reset check: assert rst for 2 cycles mid-SCAN (SETTLE=1, mask=1111, during channel 1) -> next cycle sel=00, busy=0, data_valid=0, data_out=0; a following start with mux inputs i0..i3=1,0,1,1 yields data_out=1101.
- Full scan: SETTLE=1, mask=1111, mux inputs i0..i3 = 0,1,1,0 -> sel sequence 00,00,01,01,10,10,11,11; data_valid rises after edge 8; data_out=0110.
- Sparse mask: SETTLE=0, mask=1010, i1=1, i3=1 -> sel visits 01 then 11 only; data_valid after edge 2; data_out=1010. Repeat with mask=0000 -> data_valid after edge 0, data_out=0000, sel never leaves 00.
- Backpressure: hold data_ready=0 for 10 cycles after data_valid -> data_out and data_valid stable, busy=1, and start pulses are ignored. Raise data_ready -> transfer on the next edge, then IDLE.
- Settle boundary: SETTLE=7, mask=0100, toggle i2 1→0 at cycle 5 after start -> sampled value is 0 (sampled at edge 8); data_valid after edge 8.
- Start-at-handshake: pulse start in the same cycle as data_valid&data_ready -> start is ignored, block returns to IDLE; a new start one cycle later is accepted.
